ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the shooting game's keyboard port. It is the counterpart of the keyboard receiver inside `main`. It sends command bytes to the keyboard (reset 0xFF, set-LEDs 0xED, typematic rate 0xF3) using the PS/2 host request-to-send protocol. The block drives the open-collector `ps2_clk`/`ps2_data` pads through output-enable bits and flags the receiver to ignore the lines while a transfer is in progress.

---
 rtl/ps2_host_tx.sv | 121 ++++++++++++
 tb/tb_ps2_host_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (request-to-send, shift, ack, timeout)
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2500,
  parameter int RTS_CYC     = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int CW = $clog2((INHIBIT_CYC > RTS_CYC ? INHIBIT_CYC : RTS_CYC) + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t        state;
  logic [2:0]    c_sync;
  logic [1:0]    d_sync;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          nack;
  logic          fall;
  // sync flops idle high so leaving reset never fakes a falling edge
  assign fall = c_sync[2] & ~c_sync[1];
  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      c_sync      <= '1;
      d_sync      <= '1;
      shreg       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      nack        <= 1'b0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      rx_inhibit  <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      c_sync  <= {c_sync[1:0], ps2_clk_in};
      d_sync  <= {d_sync[0], ps2_data_in};
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg      <= {1'b1, ~^tx_data, tx_data};
            bit_cnt    <= '0;
            cnt        <= '0;
            state      <= INHIBIT;
            ps2_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            rx_inhibit <= 1'b1;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt == CW'(INHIBIT_CYC - 1)) begin
            cnt         <= '0;
            state       <= RTS;
            ps2_data_oe <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RTS: begin
          tcnt <= '0;
          if (cnt == CW'(RTS_CYC - 1)) begin
            state      <= SHIFT;
            ps2_clk_oe <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // SHIFT, ACK and WAIT_IDLE all share the one timeout budget
          if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            rx_inhibit  <= 1'b0;
            tx_err      <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (state == SHIFT && fall) begin
              if (bit_cnt == 4'd10) begin
                state       <= ACK;
                nack        <= d_sync[1];
                ps2_data_oe <= 1'b0;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= shreg >> 1;
                bit_cnt     <= bit_cnt + 1'b1;
              end
            end else if (state == ACK) begin
              state <= WAIT_IDLE;
            end else if (state == WAIT_IDLE && c_sync[1] && d_sync[1]) begin
              state      <= IDLE;
              rx_inhibit <= 1'b0;
              tx_done    <= ~nack;
              tx_err     <= nack;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int HALF = 100;
  logic       board_clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done, tx_err;
  logic       dev_clk, dev_data;
  wire        ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  wire        ps2_data_in = ~ps2_data_oe & dev_data;
  int errors = 0, checks = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0, err_cnt = 0;
  int hs_cyc = 0, done_cyc = 0, err_cyc = 0, clk_on_cyc = 0, clk_off_cyc = 0, data_on_cyc = 0;
  int low_run = 0, last_low = 0;
  logic armed = 1'b0, prev_clk = 1'b0, err_prev_clk = 1'b0, err_inh = 1'b0;
  logic [1:0] err_oe = '0;

  ps2_host_tx #(.INHIBIT_CYC(50), .RTS_CYC(8), .TIMEOUT_CYC(5000)) dut (
    .board_clk(board_clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #20 board_clk = ~board_clk;

  always @(negedge board_clk) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready) begin hs_cnt = hs_cnt + 1; hs_cyc = cyc; armed = 1'b1; end
    if (tx_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (tx_err) begin
      err_cnt = err_cnt + 1; err_cyc = cyc;
      err_oe = {ps2_clk_oe, ps2_data_oe}; err_inh = rx_inhibit; err_prev_clk = prev_clk;
    end
    if (ps2_clk_oe && !prev_clk) clk_on_cyc = cyc;
    if (!ps2_clk_oe && prev_clk) begin clk_off_cyc = cyc; last_low = low_run; end
    low_run = ps2_clk_oe ? low_run + 1 : 0;
    if (armed && ps2_data_oe) begin data_on_cyc = cyc; armed = 1'b0; end
    prev_clk = ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(posedge board_clk); #1;
    tx_data = b; tx_valid = 1'b1;
    @(negedge board_clk);
    while (!tx_ready && t < 20000) begin @(negedge board_clk); t++; end
    chk("send_ready_bound", 32'(t < 20000), 1);
    @(posedge board_clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge board_clk);
    while (!tx_ready && t < 10000) begin @(negedge board_clk); t++; end
    chk("idle_bound", 32'(t < 10000), 1);
  endtask

  // Device: bits[0]=start, [8:1]=data, [9]=parity, [10]=stop, read mid-low-phase
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] bits);
    int t = 0;
    bits = '0;
    while (!ps2_clk_oe && t < 20000) begin @(negedge board_clk); t++; end
    while (ps2_clk_oe && t < 20000) begin @(negedge board_clk); t++; end
    chk("dev_release_bound", 32'(t < 20000), 1);
    repeat (HALF) @(negedge board_clk);
    bits[0] = ps2_data_in;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) begin dev_data = 1'b0; repeat (20) @(negedge board_clk); end
      dev_clk = 1'b0;
      if (i == nfalls && nfalls < 11) return;
      repeat (HALF) @(negedge board_clk);
      if (i <= 10) bits[i] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge board_clk);
    end
    dev_data = 1'b1;
  endtask

  initial begin
    logic [10:0] b1, b2;
    int d0, e0, h0, d1c, h2c, t;
    reset = 1'b0; tx_valid = 1'b0; tx_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(posedge board_clk); #1;
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_flags", {29'd0, rx_inhibit, tx_done, tx_err}, 0);
    reset = 1'b1;

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    dev_frame(11, 1'b1, b1);
    wait_idle();
    chk("ed_start", 32'(b1[0]), 0);
    chk("ed_data", 32'(b1[8:1]), 32'h00ED);
    chk("ed_parity", 32'(b1[9]), 1);
    chk("ed_stop", 32'(b1[10]), 1);
    chk("ed_done", 32'(done_cnt - d0), 1);
    chk("ed_err", 32'(err_cnt - e0), 0);
    chk("ed_clk_low", 32'(last_low), 58);
    chk("ed_clk_on", 32'(clk_on_cyc - hs_cyc), 1);
    chk("ed_data_on", 32'(data_on_cyc - hs_cyc), 51);
    chk("ed_release", 32'(clk_off_cyc - hs_cyc), 59);

    // parity extremes
    d0 = done_cnt;
    send(8'h01); dev_frame(11, 1'b1, b1); wait_idle();
    chk("p01_data", 32'(b1[8:1]), 32'h0001);
    chk("p01_parity", 32'(b1[9]), 0);
    send(8'hFF); dev_frame(11, 1'b1, b1); wait_idle();
    chk("pff_data", 32'(b1[8:1]), 32'h00FF);
    chk("pff_parity", 32'(b1[9]), 1);
    chk("parity_done", 32'(done_cnt - d0), 2);

    // NACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF3); dev_frame(11, 1'b0, b1); wait_idle();
    chk("nack_err", 32'(err_cnt - e0), 1);
    chk("nack_done", 32'(done_cnt - d0), 0);
    chk("nack_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("nack_ready", 32'(tx_ready), 1);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00); wait_idle();
    chk("to_err", 32'(err_cnt - e0), 1);
    chk("to_done", 32'(done_cnt - d0), 0);
    chk("to_latency", 32'(err_cyc - clk_off_cyc), 5000);
    chk("to_oe", 32'(err_oe), 0);
    chk("to_prev_clk", 32'(err_prev_clk), 0);
    chk("to_inhibit", 32'(err_inh), 0);

    // async reset after the 4th fall
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00); dev_frame(4, 1'b1, b1);
    repeat (20) @(negedge board_clk);
    chk("mid_data_oe", 32'(ps2_data_oe), 1);
    @(posedge board_clk); #3;
    reset = 1'b0; #1;
    chk("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    chk("mid_rst_ready", {30'd0, tx_ready, rx_inhibit}, 2);
    dev_clk = 1'b1;
    repeat (5) @(posedge board_clk); #1;
    reset = 1'b1;
    @(negedge board_clk);
    chk("post_rst_ready", 32'(tx_ready), 1);
    chk("rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    send(8'hFF); dev_frame(11, 1'b1, b1); wait_idle();
    chk("post_rst_data", 32'(b1[8:1]), 32'h00FF);
    chk("post_rst_done", 32'(done_cnt - d0), 1);

    // tx_valid held through two transfers
    h0 = hs_cnt; d0 = done_cnt;
    @(posedge board_clk); #1;
    tx_data = 8'hF3; tx_valid = 1'b1;
    t = 0;
    @(negedge board_clk);
    while (!tx_ready && t < 20000) begin @(negedge board_clk); t++; end
    @(posedge board_clk); #1;
    tx_data = 8'h20;
    dev_frame(11, 1'b1, b1);
    t = 0;
    @(negedge board_clk);
    while (!(tx_valid && tx_ready) && t < 20000) begin @(negedge board_clk); t++; end
    chk("b2b_hs2_bound", 32'(t < 20000), 1);
    @(posedge board_clk); #1;
    d1c = done_cyc; h2c = hs_cyc;
    tx_data = 8'h55; tx_valid = 1'b0;
    dev_frame(11, 1'b1, b2);
    wait_idle();
    repeat (100) @(negedge board_clk);
    chk("b2b_first", 32'(b1[8:1]), 32'h00F3);
    chk("b2b_second", 32'(b2[8:1]), 32'h0020);
    chk("b2b_hs_gap", 32'(h2c - d1c), 1);
    chk("b2b_count", 32'(hs_cnt - h0), 2);
    chk("b2b_done", 32'(done_cnt - d0), 2);
    chk("b2b_quiet", {30'd0, ps2_clk_oe, tx_ready}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
